// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer with imem handshake, stall hold and redirect/flush handling.
// Optional PC_FETCH_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VECTOR with a sticky flag.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR = 32'h00000080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_new,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign_err
);
  typedef enum logic [1:0] {FETCH, WAIT, PEND} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pend, pend_nx, instr_nx, pc_out_nx, tgt;
  logic valid_nx, req_en, redir, rdy;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = pc_new[1:0] != 2'b00;
  assign tgt = misalign ? TRAP_VECTOR : pc_new;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_err <= 1'b0;
    else if (redir && misalign) misalign_err <= 1'b1;
`else
  assign tgt = pc_new & 32'hFFFF_FFFC;
  assign misalign_err = 1'b0;
`endif
  assign redir = pc_src == 2'd1;
  // req_en keeps the first post-reset cycle request-free, so no response is consumed then
  assign rdy = imem_ready && req_en;
  assign imem_req = req_en && state != PEND;
  assign imem_addr = pc;
  assign pc_plus4 = pc_out + 32'd4;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    pend_nx = pend;
    instr_nx = instr_out;
    pc_out_nx = pc_out;
    valid_nx = instr_valid;
    if (redir) begin
      valid_nx = 1'b0;
      if (state != FETCH && !rdy) begin
        pend_nx = tgt;
        state_nx = PEND;
      end else begin
        pc_nx = tgt;
        state_nx = FETCH;
      end
    end else if (state == PEND) begin
      pc_nx = rdy ? pend : pc;
      state_nx = rdy ? FETCH : PEND;
    end else if (stall) begin
      state_nx = (req_en && !imem_ready) ? WAIT : FETCH;
    end else begin
      valid_nx = rdy;
      state_nx = (req_en && !imem_ready) ? WAIT : FETCH;
      if (rdy) begin
        instr_nx = imem_data;
        pc_out_nx = pc;
        pc_nx = pc + 32'd4;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      pend <= 32'h0;
      instr_out <= 32'h0;
      pc_out <= RESET_PC;
      instr_valid <= 1'b0;
      flush <= 1'b0;
      req_en <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      pend <= pend_nx;
      instr_out <= instr_nx;
      pc_out <= pc_out_nx;
      instr_valid <= valid_nx;
      flush <= redir;
      req_en <= 1'b1;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] pc_src = 2'd0;
  logic [31:0] pc_new = 32'h0, imem_data = 32'h0;
  logic stall = 1'b0, imem_ready = 1'b0;
  logic imem_req, instr_valid, flush, misalign_err;
  logic [31:0] imem_addr, instr_out, pc_out, pc_plus4;
  int checks = 0, failures = 0;
  bit started, waiting, pending, e_valid, e_flush, e_err;
  logic [31:0] e_pc, e_instr, e_pcout, pend_tgt;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_new(pc_new), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .flush(flush), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    started = 0; waiting = 0; pending = 0; e_valid = 0; e_flush = 0; e_err = 0;
    e_pc = 32'h0; e_instr = 32'h0; e_pcout = 32'h0; pend_tgt = 32'h0;
  endtask

  function automatic logic [31:0] target(input logic [31:0] a);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    return (a % 4 != 0) ? 32'h80 : a;
`else
    return a - (a % 4);
`endif
  endfunction

  // Behavioural view: a fetch is consumed when memory answers an issued request;
  // a redirect while a request is still in flight must wait for that stale answer.
  task automatic model_edge();
    bit took = imem_ready && started;
    e_flush = (pc_src == 2'd1);
    if (pc_src == 2'd1) begin
      e_valid = 0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      if (pc_new % 4 != 0) e_err = 1;
`endif
      if ((waiting || pending) && !took) begin
        pending = 1; pend_tgt = target(pc_new);
      end else begin
        pending = 0; e_pc = target(pc_new);
      end
      waiting = 0;
    end else if (pending) begin
      if (took) begin pending = 0; e_pc = pend_tgt; end
    end else if (stall) begin
      waiting = started && !took;
    end else begin
      e_valid = took;
      if (took) begin e_instr = imem_data; e_pcout = e_pc; e_pc = e_pc + 32'd4; end
      waiting = started && !took;
    end
    started = 1;
  endtask

  task automatic compare_all();
    chk("imem_req", 32'(imem_req), 32'(started && !pending));
    chk("imem_addr", imem_addr, e_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instr_out", instr_out, e_instr);
    chk("pc_out", pc_out, e_pcout);
    chk("pc_plus4", pc_plus4, e_pcout + 32'd4);
    chk("flush", 32'(flush), 32'(e_flush));
    chk("misalign_err", 32'(misalign_err), 32'(e_err));
  endtask

  task automatic step(input logic [1:0] src, input logic [31:0] tgt, input logic stl,
                      input logic rdy, input logic [31:0] data);
    pc_src = src; pc_new = tgt; stall = stl; imem_ready = rdy; imem_data = data;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    // back-to-back fetches from reset
    step(2'd0, 0, 0, 1, 32'h11);
    chk("first_req", 32'(imem_req), 32'h1);
    step(2'd0, 0, 0, 1, 32'h11);
    chk("seq0_pc", pc_out, 32'h0);
    chk("seq0_instr", instr_out, 32'h11);
    step(2'd0, 0, 0, 1, 32'h22);
    chk("seq1_pc", pc_out, 32'h4);
    step(2'd0, 0, 0, 1, 32'h33);
    chk("seq2_pc", pc_out, 32'h8);
    chk("seq2_plus4", pc_plus4, 32'hC);
    chk("seq2_valid", 32'(instr_valid), 32'h1);
    // slow memory at 0x10
    step(2'd1, 32'h10, 0, 1, 32'h99);
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 0, 0, 0, 32'h0);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid", 32'(instr_valid), 32'h0);
    end
    step(2'd0, 0, 0, 1, 32'hAB);
    chk("slow_instr", instr_out, 32'hAB);
    chk("slow_pc", pc_out, 32'h10);
    // redirect beats stall
    step(2'd1, 32'h400, 1, 1, 32'hDEAD);
    chk("stall_redir_flush", 32'(flush), 32'h1);
    chk("stall_redir_addr", imem_addr, 32'h400);
    chk("stall_redir_valid", 32'(instr_valid), 32'h0);
    step(2'd0, 0, 0, 0, 32'h0);
    chk("flush_one_cycle", 32'(flush), 32'h0);
    // redirect while waiting on memory
    step(2'd0, 0, 0, 0, 32'h0);
    step(2'd1, 32'h200, 0, 0, 32'h0);
    chk("pend_flush", 32'(flush), 32'h1);
    chk("pend_req", 32'(imem_req), 32'h0);
    step(2'd0, 0, 0, 0, 32'h0);
    chk("pend_flush_once", 32'(flush), 32'h0);
    step(2'd0, 0, 0, 1, 32'hBAD);
    chk("pend_addr", imem_addr, 32'h200);
    chk("pend_drop", 32'(instr_valid), 32'h0);
    // address wrap
    step(2'd1, 32'hFFFF_FFFC, 0, 1, 32'h0);
    step(2'd0, 0, 0, 1, 32'h5A5A);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    // misaligned redirect
    step(2'd1, 32'h402, 0, 1, 32'h0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", imem_addr, 32'h80);
    chk("mis_err", 32'(misalign_err), 32'h1);
`else
    chk("mis_addr", imem_addr, 32'h400);
    chk("mis_err", 32'(misalign_err), 32'h0);
`endif
    step(2'd1, 32'h800, 0, 1, 32'h0);
    step(2'd0, 0, 0, 1, 32'h1);
    // reset in the middle of a WAIT
    step(2'd0, 0, 0, 0, 32'h0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(2'd0, 0, 0, 1, 32'h77);
    step(2'd0, 0, 0, 1, 32'h78);
    chk("midrst_instr", instr_out, 32'h78);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      logic [31:0] a;
      s = ($urandom_range(0, 9) < 2) ? 2'd1 : 2'($urandom_range(0, 3) == 0 ? $urandom_range(2, 3) : 0);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      step(s, a, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
